// File: rtl/rvfi_csr_unit.sv
// rvfi_csr_unit: executes CSR instructions on misa/mcycle/minstret and reports them on RVFI CSR channels.
// Define RVFI_CSR_USER_COUNTERS_EN to expose the user counter aliases C00/C02 (and C80/C82 when XLEN=32).
module rvfi_csr_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] MISA_VALUE = XLEN'(32'h4000_0100)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_insn,
    input  logic [XLEN-1:0] req_rs1_rdata,
    input  logic [1:0]      req_mode,
    input  logic            retire,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_trap,
    output logic [4:0]      resp_rd_addr,
    output logic [XLEN-1:0] resp_rd_wdata,
    output logic [63:0]     csr_misa_rmask,
    output logic [63:0]     csr_misa_wmask,
    output logic [63:0]     csr_misa_rdata,
    output logic [63:0]     csr_misa_wdata,
    output logic [63:0]     csr_mcycle_rmask,
    output logic [63:0]     csr_mcycle_wmask,
    output logic [63:0]     csr_mcycle_rdata,
    output logic [63:0]     csr_mcycle_wdata,
    output logic [63:0]     csr_minstret_rmask,
    output logic [63:0]     csr_minstret_wmask,
    output logic [63:0]     csr_minstret_rdata,
    output logic [63:0]     csr_minstret_wdata
);
    typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic            trap_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] rd_wdata_q;
    logic [63:0]     rmask_q [3];
    logic [63:0]     wmask_q [3];
    logic [63:0]     rdata_q [3];
    logic [63:0]     wdata_q [3];

    logic            accept_s, impl_s, wr_s, trap_s, hi_s, eff_wr_s, unused_opcode_s;
    logic [11:0]     addr_s;
    logic [4:0]      rd_s, zimm_s;
    logic [2:0]      funct3_s;
    logic [1:0]      sel_s;
    logic [XLEN-1:0] op_s, old_x_s, new_x_s;
    logic [63:0]     old_s, new_s, post_s, acc_mask_s, shifted_s;

    assign addr_s          = req_insn[31:20];
    assign zimm_s          = req_insn[19:15];
    assign funct3_s        = req_insn[14:12];
    assign rd_s            = req_insn[11:7];
    assign unused_opcode_s = ^req_insn[6:0];
    assign accept_s        = req_valid && (state_q == IDLE);

    // Implemented-address table
    always_comb begin
        impl_s = 1'b0;
        case (addr_s)
            12'h301, 12'hB00, 12'hB02: impl_s = 1'b1;
            12'hB80, 12'hB82:          impl_s = (XLEN == 32);
`ifdef RVFI_CSR_USER_COUNTERS_EN
            12'hC00, 12'hC02:          impl_s = 1'b1;
            12'hC80, 12'hC82:          impl_s = (XLEN == 32);
`endif
            default:                   impl_s = 1'b0;
        endcase
    end

    // sel_s: 0 = misa, 1 = mcycle, 2 = minstret; addr[7] picks the upper half on RV32
    assign sel_s      = (addr_s == 12'h301) ? 2'd0 : (addr_s[1] ? 2'd2 : 2'd1);
    assign hi_s       = (XLEN == 32) && addr_s[7];
    assign acc_mask_s = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF :
                        (hi_s ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF);

    // Pre-value of the selected CSR
    always_comb begin
        old_s = 64'd0;
        case (sel_s)
            2'd0:    old_s = 64'(MISA_VALUE);
            2'd1:    old_s = mcycle_q;
            2'd2:    old_s = minstret_q;
            default: old_s = 64'd0;
        endcase
    end

    assign old_x_s = hi_s ? old_s[63:64-XLEN] : old_s[XLEN-1:0];
    assign op_s    = funct3_s[2] ? XLEN'(zimm_s) : req_rs1_rdata;

    // Read-modify-write operation on the accessed half
    always_comb begin
        new_x_s = op_s;
        case (funct3_s[1:0])
            2'd1:    new_x_s = op_s;
            2'd2:    new_x_s = old_x_s | op_s;
            default: new_x_s = old_x_s & ~op_s;
        endcase
    end

    assign shifted_s = hi_s ? (64'(new_x_s) << 32) : 64'(new_x_s);
    assign new_s     = (old_s & ~acc_mask_s) | (shifted_s & acc_mask_s);
    assign wr_s      = !req_insn[13] || (zimm_s != 5'd0);
    assign trap_s    = !impl_s || (funct3_s[1:0] == 2'd0) ||
                       ((addr_s[11:10] == 2'b11) && wr_s) || (addr_s[9:8] > req_mode);
    // misa is WARL read-only: a legal write leaves it untouched
    assign eff_wr_s  = wr_s && !trap_s && (sel_s != 2'd0);
    assign post_s    = eff_wr_s ? new_s : old_s;

    // A CSR write to a counter overrides that cycle's increment
    assign mcycle_d   = (accept_s && eff_wr_s && (sel_s == 2'd1)) ? new_s : (mcycle_q + 64'd1);
    assign minstret_d = (accept_s && eff_wr_s && (sel_s == 2'd2)) ? new_s :
                        (minstret_q + {63'd0, retire} + {63'd0, accept_s && !trap_s});

    // Handshake FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = RESP;
                else           state_d = IDLE;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
                else            state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Response capture on accept; held until the next accept
    always_ff @(posedge clock) begin
        if (reset) begin
            trap_q     <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_wdata_q <= '0;
            for (int i = 0; i < 3; i++) begin
                rmask_q[i] <= 64'd0;
                wmask_q[i] <= 64'd0;
                rdata_q[i] <= 64'd0;
                wdata_q[i] <= 64'd0;
            end
        end else if (accept_s) begin
            trap_q     <= trap_s;
            rd_addr_q  <= trap_s ? 5'd0 : rd_s;
            rd_wdata_q <= (trap_s || (rd_s == 5'd0)) ? '0 : old_x_s;
            for (int i = 0; i < 3; i++) begin
                rmask_q[i] <= (!trap_s && (sel_s == 2'(i))) ? acc_mask_s : 64'd0;
                wmask_q[i] <= (eff_wr_s && (sel_s == 2'(i))) ? acc_mask_s : 64'd0;
                rdata_q[i] <= (!trap_s && (sel_s == 2'(i))) ? old_s : 64'd0;
                wdata_q[i] <= (!trap_s && (sel_s == 2'(i))) ? post_s : 64'd0;
            end
        end
    end

    assign req_ready          = (state_q == IDLE);
    assign resp_valid         = (state_q == RESP);
    assign resp_trap          = trap_q;
    assign resp_rd_addr       = rd_addr_q;
    assign resp_rd_wdata      = rd_wdata_q;
    assign csr_misa_rmask     = rmask_q[0];
    assign csr_misa_wmask     = wmask_q[0];
    assign csr_misa_rdata     = rdata_q[0];
    assign csr_misa_wdata     = wdata_q[0];
    assign csr_mcycle_rmask   = rmask_q[1];
    assign csr_mcycle_wmask   = wmask_q[1];
    assign csr_mcycle_rdata   = rdata_q[1];
    assign csr_mcycle_wdata   = wdata_q[1];
    assign csr_minstret_rmask = rmask_q[2];
    assign csr_minstret_wmask = wmask_q[2];
    assign csr_minstret_rdata = rdata_q[2];
    assign csr_minstret_wdata = wdata_q[2];
endmodule

// File: tb/tb_rvfi_csr_unit.sv
// tb_rvfi_csr_unit: directed and random CSR traffic checked against a behavioural counter/CSR model.
module tb_rvfi_csr_unit;
    localparam logic [63:0] MISA = 64'h0000_0000_4000_0100;
`ifdef RVFI_CSR_USER_COUNTERS_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, retire, resp_valid, resp_ready, resp_trap;
    logic [31:0] req_insn, req_rs1_rdata, resp_rd_wdata;
    logic [1:0]  req_mode;
    logic [4:0]  resp_rd_addr;
    logic [63:0] csr_misa_rmask, csr_misa_wmask, csr_misa_rdata, csr_misa_wdata;
    logic [63:0] csr_mcycle_rmask, csr_mcycle_wmask, csr_mcycle_rdata, csr_mcycle_wdata;
    logic [63:0] csr_minstret_rmask, csr_minstret_wmask, csr_minstret_rdata, csr_minstret_wdata;

    always #5 clock = ~clock;

    rvfi_csr_unit dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1_rdata(req_rs1_rdata), .req_mode(req_mode),
        .retire(retire), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_trap(resp_trap), .resp_rd_addr(resp_rd_addr), .resp_rd_wdata(resp_rd_wdata),
        .csr_misa_rmask(csr_misa_rmask), .csr_misa_wmask(csr_misa_wmask),
        .csr_misa_rdata(csr_misa_rdata), .csr_misa_wdata(csr_misa_wdata),
        .csr_mcycle_rmask(csr_mcycle_rmask), .csr_mcycle_wmask(csr_mcycle_wmask),
        .csr_mcycle_rdata(csr_mcycle_rdata), .csr_mcycle_wdata(csr_mcycle_wdata),
        .csr_minstret_rmask(csr_minstret_rmask), .csr_minstret_wmask(csr_minstret_wmask),
        .csr_minstret_rdata(csr_minstret_rdata), .csr_minstret_wdata(csr_minstret_wdata)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    bit          acc_now = 1'b0;
    bit          rand_retire = 1'b0;
    logic [63:0] m_cyc, m_ins;
    logic        e_trap;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [63:0] e_rm [3];
    logic [63:0] e_wm [3];
    logic [63:0] e_rdata [3];
    logic [63:0] e_wdata [3];
    logic [11:0] addr_tab [9] = '{12'h301, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                  12'hC00, 12'hC02, 12'hC80, 12'hC82};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural model of one accepted CSR instruction (k: 0 misa, 1 mcycle, 2 minstret)
    task automatic model_accept(input logic [63:0] pre_c, input logic [63:0] pre_i);
        logic [11:0] a;
        logic [4:0]  rd, zf;
        logic [2:0]  f3;
        logic [31:0] op, oldh, newh;
        logic [63:0] pre, post;
        bit          impl, wr, trap, upper;
        int          k;
        a  = req_insn[31:20];
        zf = req_insn[19:15];
        f3 = req_insn[14:12];
        rd = req_insn[11:7];
        op = f3[2] ? {27'd0, zf} : req_rs1_rdata;
        wr = (req_insn[13] == 1'b0) || (zf != 5'd0);
        case (a)
            12'h301, 12'hB00, 12'hB02, 12'hB80, 12'hB82: impl = 1'b1;
            12'hC00, 12'hC02, 12'hC80, 12'hC82:          impl = USER_EN;
            default:                                     impl = 1'b0;
        endcase
        trap  = !impl || (f3[1:0] == 2'd0) || ((a[11:10] == 2'b11) && wr) || (a[9:8] > req_mode);
        k     = (a == 12'h301) ? 0 : (a[1] ? 2 : 1);
        pre   = (k == 0) ? MISA : ((k == 1) ? pre_c : pre_i);
        upper = a[7];
        oldh  = upper ? pre[63:32] : pre[31:0];
        case (f3[1:0])
            2'd1:    newh = op;
            2'd2:    newh = oldh | op;
            default: newh = oldh & ~op;
        endcase
        post = pre;
        if (wr && (k != 0)) begin
            if (upper) post[63:32] = newh;
            else       post[31:0]  = newh;
        end
        for (int i = 0; i < 3; i++) begin
            e_rm[i] = 64'd0; e_wm[i] = 64'd0; e_rdata[i] = 64'd0; e_wdata[i] = 64'd0;
        end
        e_trap = trap;
        e_rd   = trap ? 5'd0 : rd;
        e_wd   = (trap || (rd == 5'd0)) ? 32'd0 : oldh;
        if (!trap) begin
            m_ins      = m_ins + 64'd1;
            e_rm[k]    = upper ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;
            e_wm[k]    = (wr && (k != 0)) ? e_rm[k] : 64'd0;
            e_rdata[k] = pre;
            e_wdata[k] = post;
            if (wr && (k == 1)) m_cyc = post;
            if (wr && (k == 2)) m_ins = post;
        end
    endtask

    // One clock: model follows the edge, bench returns on the falling edge
    task automatic tick();
        logic [63:0] pre_c, pre_i;
        @(posedge clock);
        if (reset) begin
            m_cyc = 64'd0;
            m_ins = 64'd0;
        end else begin
            pre_c = m_cyc;
            pre_i = m_ins;
            m_cyc = pre_c + 64'd1;
            m_ins = pre_i + (retire ? 64'd1 : 64'd0);
            if (acc_now) model_accept(pre_c, pre_i);
        end
        @(negedge clock);
        retire = rand_retire ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic check_resp(input string tag);
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, ".trap"}, 64'(resp_trap), 64'(e_trap));
        chk({tag, ".rd_addr"}, 64'(resp_rd_addr), 64'(e_rd));
        chk({tag, ".rd_wdata"}, 64'(resp_rd_wdata), 64'(e_wd));
        chk({tag, ".misa_rmask"}, csr_misa_rmask, e_rm[0]);
        chk({tag, ".misa_wmask"}, csr_misa_wmask, e_wm[0]);
        chk({tag, ".misa_rdata"}, csr_misa_rdata, e_rdata[0]);
        chk({tag, ".misa_wdata"}, csr_misa_wdata, e_wdata[0]);
        chk({tag, ".mcycle_rmask"}, csr_mcycle_rmask, e_rm[1]);
        chk({tag, ".mcycle_wmask"}, csr_mcycle_wmask, e_wm[1]);
        chk({tag, ".mcycle_rdata"}, csr_mcycle_rdata, e_rdata[1]);
        chk({tag, ".mcycle_wdata"}, csr_mcycle_wdata, e_wdata[1]);
        chk({tag, ".minstret_rmask"}, csr_minstret_rmask, e_rm[2]);
        chk({tag, ".minstret_wmask"}, csr_minstret_wmask, e_wm[2]);
        chk({tag, ".minstret_rdata"}, csr_minstret_rdata, e_rdata[2]);
        chk({tag, ".minstret_wdata"}, csr_minstret_wdata, e_wdata[2]);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".trap"}, 64'(resp_trap), 64'd0);
        chk({tag, ".rd_addr"}, 64'(resp_rd_addr), 64'd0);
        chk({tag, ".rd_wdata"}, 64'(resp_rd_wdata), 64'd0);
        chk({tag, ".csr_or"}, csr_misa_rmask | csr_misa_wmask | csr_misa_rdata | csr_misa_wdata |
            csr_mcycle_rmask | csr_mcycle_wmask | csr_mcycle_rdata | csr_mcycle_wdata |
            csr_minstret_rmask | csr_minstret_wmask | csr_minstret_rdata | csr_minstret_wdata, 64'd0);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rd,
                         input logic [4:0] rs1f, input logic [31:0] val, input logic [1:0] mode,
                         input string tag);
        req_insn      = {a, rs1f, f3, rd, 7'h73};
        req_rs1_rdata = val;
        req_mode      = mode;
        req_valid     = 1'b1;
        acc_now       = 1'b1;
        tick();
        req_valid = 1'b0;
        acc_now   = 1'b0;
        check_resp(tag);
    endtask

    task automatic finish_resp(input int hold, input string tag);
        for (int h = 0; h < hold; h++) begin
            tick();
            check_resp({tag, ".hold"});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, ".done_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, ".done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; retire = 1'b0;
        req_insn = 32'd0; req_rs1_rdata = 32'd0; req_mode = 2'd3;
        repeat (3) tick();
        check_idle_zero("reset");
        reset = 1'b0;

        // mcycle read at cycle 10
        repeat (10) tick();
        issue(3'd2, 12'hB00, 5'd5, 5'd0, 32'd0, 2'd3, "mcycle10");
        chk("mcycle10.value", 64'(resp_rd_wdata), 64'd10);
        chk("mcycle10.wmask", csr_mcycle_wmask, 64'd0);
        chk("mcycle10.rmask", csr_mcycle_rmask, 64'h0000_0000_FFFF_FFFF);
        finish_resp(0, "mcycle10");

        rand_retire = 1'b1;
        issue(3'd1, 12'hB02, 5'd1, 5'd2, 32'h55, 2'd3, "minstret_w");
        chk("minstret_w.wdata_lo", 64'(csr_minstret_wdata[31:0]), 64'h55);
        finish_resp(0, "minstret_w");
        repeat (4) tick();
        issue(3'd2, 12'hB02, 5'd7, 5'd0, 32'd0, 2'd3, "minstret_r");
        finish_resp(1, "minstret_r");

        issue(3'd1, 12'hB00, 5'd9, 5'd3, 32'd123, 2'd0, "umode_b00");
        chk("umode_b00.trap1", 64'(resp_trap), 64'd1);
        finish_resp(0, "umode_b00");
        issue(3'd2, 12'hC00, 5'd3, 5'd0, 32'd0, 2'd0, "umode_c00");
        chk("umode_c00.trap_cfg", 64'(resp_trap), 64'(!USER_EN));
        finish_resp(0, "umode_c00");

        issue(3'd6, 12'hC02, 5'd0, 5'd1, 32'd0, 2'd3, "ro_write");
        chk("ro_write.trap1", 64'(resp_trap), 64'd1);
        finish_resp(0, "ro_write");
        issue(3'd7, 12'h301, 5'd4, 5'd1, 32'd0, 2'd3, "misa_rci");
        chk("misa_rci.trap0", 64'(resp_trap), 64'd0);
        chk("misa_rci.value", 64'(resp_rd_wdata), MISA);
        chk("misa_rci.wmask", csr_misa_wmask, 64'd0);
        finish_resp(0, "misa_rci");

        // Stall for 3 cycles, then reset while the response is pending
        issue(3'd2, 12'hB02, 5'd8, 5'd0, 32'd0, 2'd3, "stall");
        for (int h = 0; h < 3; h++) begin
            tick();
            check_resp("stall.hold");
        end
        reset = 1'b1;
        tick();
        check_idle_zero("rst_in_resp");
        reset = 1'b0;
        issue(3'd2, 12'hB00, 5'd5, 5'd0, 32'd0, 2'd3, "post_rst_cyc");
        chk("post_rst_cyc.zero", 64'(resp_rd_wdata), 64'd0);
        finish_resp(0, "post_rst_cyc");
        issue(3'd2, 12'hB02, 5'd5, 5'd0, 32'd0, 2'd3, "post_rst_ins");
        finish_resp(0, "post_rst_ins");

        // Upper-half write with the low half about to wrap
        issue(3'd1, 12'hB00, 5'd0, 5'd6, 32'hFFFF_FFFE, 2'd3, "lo_set");
        finish_resp(0, "lo_set");
        issue(3'd1, 12'hB80, 5'd0, 5'd6, 32'd7, 2'd3, "hi_write");
        chk("hi_write.pre", csr_mcycle_rdata, 64'h0000_0000_FFFF_FFFF);
        chk("hi_write.post", csr_mcycle_wdata, 64'h0000_0007_FFFF_FFFF);
        finish_resp(0, "hi_write");
        issue(3'd2, 12'hB00, 5'd10, 5'd0, 32'd0, 2'd3, "lo_wrap");
        chk("lo_wrap.zero", 64'(resp_rd_wdata), 64'd0);
        finish_resp(0, "lo_wrap");
        issue(3'd2, 12'hB80, 5'd11, 5'd0, 32'd0, 2'd3, "hi_carry");
        chk("hi_carry.eight", 64'(resp_rd_wdata), 64'd8);
        finish_resp(0, "hi_carry");

        for (int n = 0; n < 80; n++) begin
            int          pick;
            logic [11:0] a;
            pick = $urandom_range(0, 9);
            a    = (pick == 9) ? 12'($urandom) : addr_tab[pick];
            issue(3'($urandom), a, 5'($urandom), 5'($urandom), $urandom, 2'($urandom), "rand");
            finish_resp($urandom_range(0, 2), "rand");
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
